// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV64IM five-stage core.
// One combinational read port with a bypass from the general write port,
// one general write port, and dedicated trap-entry ports for mepc, mcause
// and mtval, plus the MIE -> MPIE stacking request.
module csr_file #(
    parameter int unsigned     XLEN    = 64,
    parameter logic [XLEN-1:0] HART_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [11:0]     waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            we_mtval_i,
    input  logic [XLEN-1:0] wdata_mtval_i,
    input  logic            we_mepc_i,
    input  logic [XLEN-1:0] wdata_mepc_i,
    input  logic            we_mcause_i,
    input  logic [XLEN-1:0] wdata_mcause_i,
    input  logic            exception_mie_req_i,
    input  logic [11:0]     raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // MXL=2 (64-bit) in the top bits, extensions I and M.
    localparam logic [XLEN-1:0] MISA_VALUE = {2'b10, {(XLEN-15){1'b0}}, 13'h1100};
    // Clears the two low bits for word-aligned mepc/mtvec.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};

    // Plain full-width read/write CSRs with no side effects share one register array.
    localparam int unsigned     NUM_PLAIN   = 3;
    localparam int unsigned     PLAIN_MIE   = 0;
    localparam int unsigned     PLAIN_MSCR  = 1;
    localparam int unsigned     PLAIN_MIP   = 2;
    localparam logic [3*12-1:0] PLAIN_ADDRS = {CSR_MIP, CSR_MSCRATCH, CSR_MIE};

    logic                 mie_reg;
    logic                 mpie_reg;
    logic [XLEN-1:0]      mtvec_reg;
    logic [XLEN-1:0]      mepc_reg;
    logic [XLEN-1:0]      mcause_reg;
    logic [XLEN-1:0]      mtval_reg;
    logic [XLEN-1:0]      mcycle_reg;
    logic [XLEN-1:0]      plain_reg [NUM_PLAIN];

    logic                 wr_ok;
    logic                 wr_en;
    logic [XLEN-1:0]      wr_val;
    logic [NUM_PLAIN-1:0] plain_hit;
    logic [XLEN-1:0]      mstatus_value;
    logic [XLEN-1:0]      csr_value;

    // Legalise the general write: decide writability and apply field masking/alignment.
    always_comb begin
        wr_ok  = 1'b0;
        wr_val = wdata_i;
        case (waddr_i)
            CSR_MSTATUS: begin
                wr_ok         = 1'b1;
                wr_val        = '0;
                wr_val[12:11] = 2'b11;
                wr_val[7]     = wdata_i[7];
                wr_val[3]     = wdata_i[3];
            end
            CSR_MTVEC, CSR_MEPC: begin
                wr_ok  = 1'b1;
                wr_val = wdata_i & ALIGN_MASK;
            end
            CSR_MIE, CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE: begin
                wr_ok = 1'b1;
            end
            default: begin
                wr_ok = 1'b0;
            end
        endcase
    end

    assign wr_en = we_i & wr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAIN; gi++) begin : g_plain_hit
            assign plain_hit[gi] = wr_en && (waddr_i == PLAIN_ADDRS[gi*12 +: 12]);
        end
    endgenerate

    // Plain CSRs: general write port only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PLAIN; i++) plain_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAIN; i++) begin
                if (plain_hit[i]) plain_reg[i] <= wr_val;
            end
        end
    end

    // mstatus MIE/MPIE: trap entry stacks MIE into MPIE and overrides any general write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_reg  <= 1'b0;
            mpie_reg <= 1'b0;
        end else if (exception_mie_req_i) begin
            mpie_reg <= mie_reg;
            mie_reg  <= 1'b0;
        end else if (wr_en && waddr_i == CSR_MSTATUS) begin
            mpie_reg <= wr_val[7];
            mie_reg  <= wr_val[3];
        end
    end

    // Trap CSRs: the dedicated port wins over the general port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc_reg   <= '0;
            mcause_reg <= '0;
            mtval_reg  <= '0;
            mtvec_reg  <= '0;
        end else begin
            if (we_mepc_i)                              mepc_reg <= wdata_mepc_i & ALIGN_MASK;
            else if (wr_en && waddr_i == CSR_MEPC)      mepc_reg <= wr_val;
            if (we_mcause_i)                            mcause_reg <= wdata_mcause_i;
            else if (wr_en && waddr_i == CSR_MCAUSE)    mcause_reg <= wr_val;
            if (we_mtval_i)                             mtval_reg <= wdata_mtval_i;
            else if (wr_en && waddr_i == CSR_MTVAL)     mtval_reg <= wr_val;
            if (wr_en && waddr_i == CSR_MTVEC)          mtvec_reg <= wr_val;
        end
    end

    // Free-running cycle counter; a general write replaces the increment for that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  mcycle_reg <= '0;
        else if (wr_en && waddr_i == CSR_MCYCLE)   mcycle_reg <= wr_val;
        else                                       mcycle_reg <= mcycle_reg + ONE;
    end

    // Assemble mstatus with MPP hardwired to machine mode.
    always_comb begin
        mstatus_value        = '0;
        mstatus_value[12:11] = 2'b11;
        mstatus_value[7]     = mpie_reg;
        mstatus_value[3]     = mie_reg;
    end

    // Architectural read mux.
    always_comb begin
        csr_value = '0;
        case (raddr_i)
            CSR_MSTATUS:  csr_value = mstatus_value;
            CSR_MISA:     csr_value = MISA_VALUE;
            CSR_MIE:      csr_value = plain_reg[PLAIN_MIE];
            CSR_MTVEC:    csr_value = mtvec_reg;
            CSR_MSCRATCH: csr_value = plain_reg[PLAIN_MSCR];
            CSR_MEPC:     csr_value = mepc_reg;
            CSR_MCAUSE:   csr_value = mcause_reg;
            CSR_MTVAL:    csr_value = mtval_reg;
            CSR_MIP:      csr_value = plain_reg[PLAIN_MIP];
            CSR_MCYCLE:   csr_value = mcycle_reg;
            CSR_MHARTID:  csr_value = HART_ID;
            default:      csr_value = '0;
        endcase
    end

    // Same-cycle bypass of the legalised general write; trap ports are not forwarded.
    always_comb begin
        rdata_o = csr_value;
        if (wr_en && waddr_i == raddr_i) rdata_o = wr_val;
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [11:0] waddr_i;
    logic [63:0] wdata_i;
    logic        we_mtval_i;
    logic [63:0] wdata_mtval_i;
    logic        we_mepc_i;
    logic [63:0] wdata_mepc_i;
    logic        we_mcause_i;
    logic [63:0] wdata_mcause_i;
    logic        exception_mie_req_i;
    logic [11:0] raddr_i;
    logic [63:0] rdata_o;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] MISA_EXP = 64'h8000_0000_0000_1100;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    csr_file #(.XLEN(64), .HART_ID(64'd0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .wdata_i             (wdata_i),
        .we_mtval_i          (we_mtval_i),
        .wdata_mtval_i       (wdata_mtval_i),
        .we_mepc_i           (we_mepc_i),
        .wdata_mepc_i        (wdata_mepc_i),
        .we_mcause_i         (we_mcause_i),
        .wdata_mcause_i      (wdata_mcause_i),
        .exception_mie_req_i (exception_mie_req_i),
        .raddr_i             (raddr_i),
        .rdata_o             (rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where stimulus is driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Point the read port at an address and let the combinational path settle.
    task automatic rd(input logic [11:0] a);
        raddr_i = a;
        #1;
    endtask

    task automatic clear_writes();
        we_i = 1'b0; we_mtval_i = 1'b0; we_mepc_i = 1'b0; we_mcause_i = 1'b0;
        exception_mie_req_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [12];
        logic [63:0] exps  [12];
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hF14, 12'h7C0};
        exps  = '{64'h1800, MISA_EXP, 64'h0, 64'h0, 64'h0, 64'h0,
                  64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            rd(addrs[i]);
            checks++;
            if (rdata_o !== exps[i]) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], rdata_o, exps[i]);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        rd(12'hB00);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_mcycle_held got=%h exp=0", rdata_o);
        end
        $display("reset: done");
    endtask

    task automatic test_mcycle_count();
        step();
        rst = 1'b1;
        rd(12'hB00);
        checks++;
        if (rdata_o !== 64'd0) begin
            errors++;
            $display("FAIL mcycle_start got=%0d exp=0", rdata_o);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #2;
            checks++;
            if (rdata_o !== 64'(k)) begin
                errors++;
                $display("FAIL mcycle_count got=%0d exp=%0d", rdata_o, k);
            end
        end
        $display("mcycle: 10 increments checked");
    endtask

    task automatic test_general_write();
        step();
        we_i = 1'b1; waddr_i = 12'h340; wdata_i = 64'hDEAD_BEEF;
        rd(12'h340);
        checks++;
        if (rdata_o !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mscratch_bypass got=%h exp=deadbeef", rdata_o);
        end
        step();
        we_i = 1'b0;
        rd(12'h340);
        checks++;
        if (rdata_o !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mscratch_held got=%h exp=deadbeef", rdata_o);
        end
        $display("general_write: mscratch=%h", rdata_o);
    endtask

    task automatic test_masking();
        step();
        we_i = 1'b1; waddr_i = 12'h300; wdata_i = ALL_ONES;
        rd(12'h300);
        checks++;
        if (rdata_o !== 64'h1888) begin
            errors++;
            $display("FAIL mstatus_mask_bypass got=%h exp=1888", rdata_o);
        end
        step();
        waddr_i = 12'h341; wdata_i = 64'h3;
        rd(12'h300);
        checks++;
        if (rdata_o !== 64'h1888) begin
            errors++;
            $display("FAIL mstatus_mask_held got=%h exp=1888", rdata_o);
        end
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mepc_align_bypass got=%h exp=0", rdata_o);
        end
        step();
        waddr_i = 12'h305; wdata_i = 64'h1237;
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mepc_align_held got=%h exp=0", rdata_o);
        end
        step();
        waddr_i = 12'h301; wdata_i = 64'h0;
        rd(12'h301);
        checks++;
        if (rdata_o !== MISA_EXP) begin
            errors++;
            $display("FAIL misa_ro_bypass got=%h exp=%h", rdata_o, MISA_EXP);
        end
        rd(12'h305);
        checks++;
        if (rdata_o !== 64'h1234) begin
            errors++;
            $display("FAIL mtvec_align got=%h exp=1234", rdata_o);
        end
        step();
        waddr_i = 12'hF14; wdata_i = 64'h55;
        rd(12'hF14);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mhartid_ro_bypass got=%h exp=0", rdata_o);
        end
        step();
        waddr_i = 12'h7C0; wdata_i = 64'h77;
        rd(12'h7C0);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL unimpl_bypass got=%h exp=0", rdata_o);
        end
        step();
        we_i = 1'b0;
        rd(12'h301);
        checks++;
        if (rdata_o !== MISA_EXP) begin
            errors++;
            $display("FAIL misa_unchanged got=%h exp=%h", rdata_o, MISA_EXP);
        end
        rd(12'hF14);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mhartid_unchanged got=%h exp=0", rdata_o);
        end
        rd(12'h7C0);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL unimpl_reads_zero got=%h exp=0", rdata_o);
        end
        $display("masking: done");
    endtask

    task automatic test_trap();
        step();
        we_i = 1'b1; waddr_i = 12'h300; wdata_i = 64'h8;
        step();
        we_i = 1'b0;
        rd(12'h300);
        checks++;
        if (rdata_o !== 64'h1808) begin
            errors++;
            $display("FAIL trap_setup_mstatus got=%h exp=1808", rdata_o);
        end
        step();
        we_i = 1'b1; waddr_i = 12'h300; wdata_i = 64'h0;
        we_mepc_i = 1'b1;   wdata_mepc_i = 64'h8000_0010;
        we_mcause_i = 1'b1; wdata_mcause_i = 64'd11;
        we_mtval_i = 1'b1;  wdata_mtval_i = 64'h0;
        exception_mie_req_i = 1'b1;
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mepc_not_bypassed got=%h exp=0", rdata_o);
        end
        step();
        clear_writes();
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h8000_0010) begin
            errors++;
            $display("FAIL trap_mepc got=%h exp=80000010", rdata_o);
        end
        rd(12'h342);
        checks++;
        if (rdata_o !== 64'd11) begin
            errors++;
            $display("FAIL trap_mcause got=%h exp=b", rdata_o);
        end
        rd(12'h343);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL trap_mtval got=%h exp=0", rdata_o);
        end
        rd(12'h300);
        checks++;
        if (rdata_o !== 64'h1880) begin
            errors++;
            $display("FAIL trap_mstatus got=%h exp=1880", rdata_o);
        end
        // Second trap with MIE already clear: MPIE must pick up the 0.
        step();
        we_mepc_i = 1'b1;  wdata_mepc_i = 64'h8000_0013;
        we_mtval_i = 1'b1; wdata_mtval_i = 64'hABC;
        exception_mie_req_i = 1'b1;
        step();
        clear_writes();
        rd(12'h300);
        checks++;
        if (rdata_o !== 64'h1800) begin
            errors++;
            $display("FAIL trap2_mstatus got=%h exp=1800", rdata_o);
        end
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h8000_0010) begin
            errors++;
            $display("FAIL trap2_mepc_align got=%h exp=80000010", rdata_o);
        end
        rd(12'h343);
        checks++;
        if (rdata_o !== 64'hABC) begin
            errors++;
            $display("FAIL trap2_mtval got=%h exp=abc", rdata_o);
        end
        $display("trap: done");
    endtask

    task automatic test_conflict();
        step();
        we_i = 1'b1; waddr_i = 12'h342; wdata_i = 64'd5;
        we_mcause_i = 1'b1; wdata_mcause_i = 64'd2;
        step();
        clear_writes();
        rd(12'h342);
        checks++;
        if (rdata_o !== 64'd2) begin
            errors++;
            $display("FAIL conflict_mcause got=%0d exp=2", rdata_o);
        end
        we_i = 1'b1; waddr_i = 12'h341; wdata_i = 64'h100;
        we_mepc_i = 1'b1; wdata_mepc_i = 64'h203;
        step();
        clear_writes();
        rd(12'h341);
        checks++;
        if (rdata_o !== 64'h200) begin
            errors++;
            $display("FAIL conflict_mepc got=%h exp=200", rdata_o);
        end
        we_i = 1'b1; waddr_i = 12'h342; wdata_i = 64'd7;
        step();
        clear_writes();
        rd(12'h342);
        checks++;
        if (rdata_o !== 64'd7) begin
            errors++;
            $display("FAIL general_mcause got=%0d exp=7", rdata_o);
        end
        $display("conflict: done");
    endtask

    task automatic test_mcycle_wrap();
        step();
        we_i = 1'b1; waddr_i = 12'hB00; wdata_i = ALL_ONES;
        rd(12'hB00);
        checks++;
        if (rdata_o !== ALL_ONES) begin
            errors++;
            $display("FAIL mcycle_bypass got=%h exp=%h", rdata_o, ALL_ONES);
        end
        step();
        we_i = 1'b0;
        rd(12'hB00);
        checks++;
        if (rdata_o !== ALL_ONES) begin
            errors++;
            $display("FAIL mcycle_loaded got=%h exp=%h", rdata_o, ALL_ONES);
        end
        step();
        rd(12'hB00);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL mcycle_wrap got=%h exp=0", rdata_o);
        end
        step();
        rd(12'hB00);
        checks++;
        if (rdata_o !== 64'h1) begin
            errors++;
            $display("FAIL mcycle_after_wrap got=%h exp=1", rdata_o);
        end
        $display("mcycle_wrap: done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [3];
        vals = '{64'h1111, 64'h2222, 64'h3333};
        for (int i = 0; i < 3; i++) begin
            step();
            we_i = 1'b1; waddr_i = 12'h340; wdata_i = vals[i];
            rd(12'h340);
            checks++;
            if (rdata_o !== vals[i]) begin
                errors++;
                $display("FAIL b2b_bypass idx=%0d got=%h exp=%h", i, rdata_o, vals[i]);
            end
        end
        step();
        waddr_i = 12'h344; wdata_i = 64'hF0;
        rd(12'h340);
        checks++;
        if (rdata_o !== 64'h3333) begin
            errors++;
            $display("FAIL b2b_last got=%h exp=3333", rdata_o);
        end
        step();
        we_i = 1'b0;
        rd(12'h344);
        checks++;
        if (rdata_o !== 64'hF0) begin
            errors++;
            $display("FAIL b2b_mip got=%h exp=f0", rdata_o);
        end
        rd(12'h304);
        checks++;
        if (rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL b2b_mie_untouched got=%h exp=0", rdata_o);
        end
        $display("back_to_back: done");
    endtask

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        waddr_i = '0; wdata_i = '0; raddr_i = '0;
        wdata_mtval_i = '0; wdata_mepc_i = '0; wdata_mcause_i = '0;
        clear_writes();
        test_reset();
        test_mcycle_count();
        test_general_write();
        test_masking();
        test_trap();
        test_conflict();
        test_mcycle_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
